// File: rtl/vc2sd_if.sv
// vc2sd_if: credit-in / srdy-drdy-out bundle for vc2sd_mvc.
// master drives beats and p_drdy; slave returns credits, data and status.
interface vc2sd_if #(
  parameter int vcs   = 4,
  parameter int depth = 8,
  parameter int width = 8
);
  localparam int asz = $clog2(depth);
  localparam int vsz = $clog2(vcs);

  logic                   c_vld;
  logic [vsz-1:0]         c_vcid;
  logic [width-1:0]       c_data;
  logic [vcs-1:0]         c_cr;
  logic                   p_srdy;
  logic                   p_drdy;
  logic [vsz-1:0]         p_vcid;
  logic [width-1:0]       p_data;
  logic [vcs*(asz+1)-1:0] usage;
  logic                   ovf_err;

  modport master (
    output c_vld, c_vcid, c_data, p_drdy,
    input  c_cr, p_srdy, p_vcid, p_data, usage, ovf_err
  );

  modport slave (
    input  c_vld, c_vcid, c_data, p_drdy,
    output c_cr, p_srdy, p_vcid, p_data, usage, ovf_err
  );
endinterface

// File: rtl/vc2sd_mvc.sv
// vc2sd_mvc: per-VC FIFOs fed by a credit link, drained round-robin.
// Ports: clk, reset (sync, active-high), io (vc2sd_if.slave bundle).
module vc2sd_mvc #(
  parameter int vcs    = 4,
  parameter int depth  = 8,
  parameter int width  = 8,
  parameter int reginp = 0
) (
  input logic    clk,
  input logic    reset,
  vc2sd_if.slave io
);
  localparam int asz = $clog2(depth);
  localparam int vsz = $clog2(vcs);
  localparam int psz = asz + 1;
  localparam logic [psz-1:0] MSB = {1'b1, {asz{1'b0}}};

  logic             wv;
  logic [vsz-1:0]   wvc;
  logic [width-1:0] wd;

  generate
    if (reginp != 0) begin : g_reg
      logic             v_q;
      logic [vsz-1:0]   vc_q;
      logic [width-1:0] d_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          v_q  <= 1'b0;
          vc_q <= '0;
          d_q  <= '0;
        end else begin
          v_q  <= io.c_vld;
          vc_q <= io.c_vcid;
          d_q  <= io.c_data;
        end
      end
      assign wv  = v_q;
      assign wvc = vc_q;
      assign wd  = d_q;
    end else begin : g_comb
      assign wv  = io.c_vld;
      assign wvc = io.c_vcid;
      assign wd  = io.c_data;
    end
  endgenerate

  logic [width-1:0]       mem_q [vcs][depth];
  logic [psz-1:0]         rptr_q [vcs];
  logic [psz-1:0]         wptr_q [vcs];
  logic [psz-1:0]         rptr_d [vcs];
  logic [psz-1:0]         wptr_d [vcs];
  logic [vsz-1:0]         prio_q, gnt_q, gnt, rr, nprio;
  logic                   hold_q;
  logic [vcs-1:0]         cr_q, cr_d;
  logic                   ovf_q, ovf_set;
  logic [vcs*psz-1:0]     use_q, use_d;
  logic [vcs-1:0]         ne, full, pop, push;
  logic                   srdy, xfer, found;
  logic [psz-1:0]         head;
  int                     j;

  always_comb begin
    ne   = '0;
    full = '0;
    for (int v = 0; v < vcs; v++) begin
      ne[v]   = rptr_q[v] != wptr_q[v];
      full[v] = (rptr_q[v] ^ wptr_q[v]) == MSB;
    end
    // first non-empty VC at or after prio
    rr    = prio_q;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < vcs; i++) begin
      j = int'(prio_q) + i;
      if (j >= vcs) j = j - vcs;
      if (!found && ne[j]) begin
        rr    = vsz'(j);
        found = 1'b1;
      end
    end
    // a stalled offer keeps its grant
    gnt   = hold_q ? gnt_q : rr;
    srdy  = |ne;
    xfer  = srdy & io.p_drdy;
    nprio = (gnt == vsz'(vcs - 1)) ? '0 : gnt + 1'b1;
    pop   = '0;
    push  = '0;
    for (int v = 0; v < vcs; v++) begin
      pop[v]  = xfer && (gnt == vsz'(v));
      push[v] = wv && (wvc == vsz'(v)) && (!full[v] || pop[v]);
    end
    ovf_set = wv && full[wvc] && !pop[wvc];
    use_d   = '0;
    for (int v = 0; v < vcs; v++) begin
      rptr_d[v] = rptr_q[v] + psz'(pop[v]);
      wptr_d[v] = wptr_q[v] + psz'(push[v]);
      use_d[v*psz +: psz] = wptr_d[v] - rptr_d[v];
    end
    cr_d = xfer ? ({{(vcs-1){1'b0}}, 1'b1} << gnt) : '0;
    head = rptr_q[gnt];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < vcs; v++) begin
        rptr_q[v] <= '0;
        wptr_q[v] <= '0;
      end
      prio_q <= '0;
      gnt_q  <= '0;
      hold_q <= 1'b0;
      cr_q   <= '0;
      ovf_q  <= 1'b0;
      use_q  <= '0;
    end else begin
      for (int v = 0; v < vcs; v++) begin
        rptr_q[v] <= rptr_d[v];
        wptr_q[v] <= wptr_d[v];
      end
      if (xfer) prio_q <= nprio;
      gnt_q  <= gnt;
      hold_q <= srdy & ~io.p_drdy;
      cr_q   <= cr_d;
      ovf_q  <= ovf_q | ovf_set;
      use_q  <= use_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < vcs; v++)
      if (push[v]) mem_q[v][wptr_q[v][asz-1:0]] <= wd;
  end

  assign io.p_srdy  = srdy;
  assign io.p_vcid  = gnt;
  assign io.p_data  = mem_q[gnt][head[asz-1:0]];
  assign io.c_cr    = cr_q;
  assign io.usage   = use_q;
  assign io.ovf_err = ovf_q;
endmodule

// File: tb/tb_vc2sd_mvc.sv
// tb_vc2sd_mvc: directed and random beats vs a queue-based model.
// Checks output order, stall hold, credits, usage and overflow.
module tb_vc2sd_mvc;
  localparam int VCS   = 4;
  localparam int DEPTH = 8;
  localparam int W     = 8;
  localparam int PSZ   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vc2sd_if #(.vcs(VCS), .depth(DEPTH), .width(W)) bus ();

  vc2sd_mvc #(
    .vcs(VCS), .depth(DEPTH), .width(W), .reginp(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0]   mq [VCS][$];
  int             prio;
  bit             lock;
  int             lock_vc;
  logic [VCS-1:0] exp_cr;
  bit             exp_ovf;
  int             crcnt [VCS];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int v = 0; v < VCS; v++) mq[v].delete();
    prio = 0;
    lock = 0;
    lock_vc = 0;
    exp_cr = '0;
    exp_ovf = 0;
  endtask

  function automatic int pick();
    if (lock) return lock_vc;
    for (int i = 0; i < VCS; i++)
      if (mq[(prio + i) % VCS].size() > 0) return (prio + i) % VCS;
    return -1;
  endfunction

  task automatic step(bit rst, bit vld, int vc, logic [W-1:0] d, bit rdy);
    int g;
    bit busy;
    logic [VCS*PSZ-1:0] eu;
    @(negedge clk);
    reset = rst;
    bus.c_vld = vld;
    bus.c_vcid = 2'(vc);
    bus.c_data = d;
    bus.p_drdy = rdy;
    g = pick();
    busy = (g >= 0);
    eu = '0;
    for (int v = 0; v < VCS; v++) eu[v*PSZ +: PSZ] = PSZ'(mq[v].size());
    chk("p_srdy", 64'(bus.p_srdy), 64'(busy));
    if (busy) begin
      chk("p_vcid", 64'(bus.p_vcid), 64'(g));
      chk("p_data", 64'(bus.p_data), 64'(mq[g][0]));
    end
    chk("c_cr", 64'(bus.c_cr), 64'(exp_cr));
    chk("usage", 64'(bus.usage), 64'(eu));
    chk("ovf_err", 64'(bus.ovf_err), 64'(exp_ovf));
    for (int v = 0; v < VCS; v++) if (bus.c_cr[v]) crcnt[v]++;
    if (rst) begin
      clear_model();
      return;
    end
    exp_cr = '0;
    if (busy && rdy) begin
      void'(mq[g].pop_front());
      exp_cr[g] = 1'b1;
      prio = (g + 1) % VCS;
    end
    lock = busy && !rdy;
    lock_vc = g;
    if (vld) begin
      if (mq[vc].size() < DEPTH) mq[vc].push_back(d);
      else exp_ovf = 1;
    end
  endtask

  initial begin
    bus.c_vld = 1'b0;
    bus.c_vcid = '0;
    bus.c_data = '0;
    bus.p_drdy = 1'b0;
    clear_model();
    for (int v = 0; v < VCS; v++) crcnt[v] = 0;
    repeat (3) @(posedge clk);

    // reset then idle
    repeat (10) step(0, 0, 0, 0, 0);

    // single beat, VC2
    step(0, 1, 2, 8'hA5, 1);
    chk("t2_idle", 64'(bus.p_srdy), 64'd0);
    step(0, 0, 0, 0, 1);
    chk("t2_vcid", 64'(bus.p_vcid), 64'd2);
    chk("t2_data", 64'(bus.p_data), 64'hA5);
    step(0, 0, 0, 0, 1);
    chk("t2_cr", 64'(bus.c_cr), 64'b0100);
    repeat (2) step(0, 0, 0, 0, 1);

    // fill VC0 and VC1, then overflow VC0
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(i), 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 8'(8'h10 + i), 0);
    step(0, 1, 0, 8'hEE, 0);
    chk("t3_noovf", 64'(bus.ovf_err), 64'd0);
    step(0, 0, 0, 0, 0);
    chk("t3_ovf", 64'(bus.ovf_err), 64'd1);
    chk("t3_usage", 64'(bus.usage), 64'h0088);
    repeat (2 * DEPTH + 2) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // two beats per VC, round-robin drain
    for (int i = 0; i < 2; i++)
      for (int v = 0; v < VCS; v++) step(0, 1, v, 8'(v * 16 + i), 0);
    for (int v = 0; v < VCS; v++) crcnt[v] = 0;
    repeat (10) step(0, 0, 0, 0, 1);
    for (int v = 0; v < VCS; v++) chk("t4_crcnt", 64'(crcnt[v]), 64'd2);

    // stall hold on VC1 while VC0 fills
    step(0, 1, 1, 8'h5C, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'(8'h70 + i), 0);
      chk("t5_vcid", 64'(bus.p_vcid), 64'd1);
      chk("t5_data", 64'(bus.p_data), 64'h5C);
    end
    repeat (8) step(0, 0, 0, 0, 1);

    // reset with data buffered
    step(0, 1, 0, 8'h01, 0);
    step(0, 1, 1, 8'h02, 0);
    step(0, 1, 2, 8'h03, 0);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t6_srdy", 64'(bus.p_srdy), 64'd0);
    chk("t6_usage", 64'(bus.usage), 64'd0);
    repeat (3) step(0, 0, 0, 0, 1);

    // random traffic
    repeat (400)
      step(0, 1'($urandom_range(0, 1)), $urandom_range(0, VCS - 1),
           8'($urandom), $urandom_range(0, 3) != 0);
    repeat (40) step(0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
